// File: rtl/alu_issue_ctrl.sv
// Issue/response controller for the 32-bit combinational ALU: decodes ALUOp/funct, holds the
// operands stable while the ripple chain settles, then captures the result. Optional macro: OVF_TRAP_EN.
module alu_issue_ctrl #(
   parameter int WIDTH      = 32,
   parameter int SETTLE_CYC = 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_aluop_i,
   input  logic [5:0]       req_funct_i,
   input  logic [WIDTH-1:0] req_a_i,
   input  logic [WIDTH-1:0] req_b_i,
   output logic [3:0]       alu_ctl_o,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   input  logic [WIDTH-1:0] alu_out_i,
   input  logic             alu_zero_i,
   input  logic             alu_ovf_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [WIDTH-1:0] rsp_result_o,
   output logic             rsp_zero_o,
   output logic             rsp_ovf_o,
   output logic             rsp_illegal_o
);

   // state   | meaning
   // IDLE    | waiting for a request, req_ready high
   // EXEC    | ALU inputs held, settle counter running down
   // RESP    | response held until rsp_ready
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
   localparam logic [3:0] CTL_ADD   = 4'b0010;
   localparam logic [3:0] CTL_SUB   = 4'b0110;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       alu_ctl_q, alu_ctl_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_ovf_q, rsp_ovf_d;
   logic             rsp_illegal_q, rsp_illegal_d;

   logic [3:0]       dec_ctl;
   logic             dec_illegal;
   logic             ovf_cap;
   logic [WIDTH-1:0] res_cap;

   always_comb begin
      dec_ctl     = 4'b0000;
      dec_illegal = 1'b0;
      unique case (req_aluop_i)
         2'b00: dec_ctl = CTL_ADD;
         2'b01: dec_ctl = CTL_SUB;
         2'b10: begin
            unique case (req_funct_i)
               6'b100000: dec_ctl = CTL_ADD;
               6'b100010: dec_ctl = CTL_SUB;
               6'b100100: dec_ctl = 4'b0000;
               6'b100101: dec_ctl = 4'b0001;
               6'b101010: dec_ctl = 4'b0111;
               6'b100111: dec_ctl = 4'b1100;
               default:   dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

`ifdef OVF_TRAP_EN
   // Signed overflow judged on the effective B seen by the adder (inverted for subtract).
   logic is_addsub;
   logic b_msb_eff;
   always_comb begin
      is_addsub = (alu_ctl_q == CTL_ADD) || (alu_ctl_q == CTL_SUB);
      b_msb_eff = alu_ctl_q[2] ? ~alu_b_q[WIDTH-1] : alu_b_q[WIDTH-1];
      ovf_cap   = is_addsub && (alu_a_q[WIDTH-1] == b_msb_eff)
                  && (alu_out_i[WIDTH-1] != alu_a_q[WIDTH-1]);
      res_cap   = ovf_cap ? '0 : alu_out_i;
   end
`else
   always_comb begin
      ovf_cap = alu_ovf_i;
      res_cap = alu_out_i;
   end
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      alu_ctl_d     = alu_ctl_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_result_d  = rsp_result_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_ovf_d     = rsp_ovf_q;
      rsp_illegal_d = rsp_illegal_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (dec_illegal) begin
                  rsp_valid_d   = 1'b1;
                  rsp_result_d  = '0;
                  rsp_zero_d    = 1'b0;
                  rsp_ovf_d     = 1'b0;
                  rsp_illegal_d = 1'b1;
                  state_d       = ST_RESP;
               end else begin
                  alu_ctl_d = dec_ctl;
                  alu_a_d   = req_a_i;
                  alu_b_d   = req_b_i;
                  cnt_d     = SETTLE_LD;
                  state_d   = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               rsp_valid_d   = 1'b1;
               rsp_result_d  = res_cap;
               rsp_zero_d    = alu_zero_i;
               rsp_ovf_d     = ovf_cap;
               rsp_illegal_d = 1'b0;
               state_d       = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 4'd0;
         alu_ctl_q     <= 4'd0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_ovf_q     <= 1'b0;
         rsp_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         alu_ctl_q     <= alu_ctl_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         rsp_zero_q    <= rsp_zero_d;
         rsp_ovf_q     <= rsp_ovf_d;
         rsp_illegal_q <= rsp_illegal_d;
      end
   end

   assign req_ready_o   = (state_q == ST_IDLE);
   assign alu_ctl_o     = alu_ctl_q;
   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_result_o  = rsp_result_q;
   assign rsp_zero_o    = rsp_zero_q;
   assign rsp_ovf_o     = rsp_ovf_q;
   assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the ALU side.
module tb_alu_issue_ctrl;

   localparam int SETTLE = 3;
`ifdef OVF_TRAP_EN
   localparam logic TRAP = 1'b1;
`else
   localparam logic TRAP = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [1:0]  req_aluop_i;
   logic [5:0]  req_funct_i;
   logic [31:0] req_a_i, req_b_i;
   logic [3:0]  alu_ctl_o;
   logic [31:0] alu_a_o, alu_b_o, alu_out_i;
   logic        alu_zero_i, alu_ovf_i;
   logic        rsp_valid_o, rsp_ready_i;
   logic [31:0] rsp_result_o;
   logic        rsp_zero_o, rsp_ovf_o, rsp_illegal_o;

   int n_vec  = 0;
   int n_miss = 0;

   alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYC(SETTLE)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_aluop_i(req_aluop_i), .req_funct_i(req_funct_i),
      .req_a_i(req_a_i), .req_b_i(req_b_i),
      .alu_ctl_o(alu_ctl_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .alu_out_i(alu_out_i), .alu_zero_i(alu_zero_i), .alu_ovf_i(alu_ovf_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o),
      .rsp_ovf_o(rsp_ovf_o), .rsp_illegal_o(rsp_illegal_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural 32-bit ALU; ovf is the carry-out of bit 31.
   logic [32:0] sum;
   always_comb begin
      sum       = 33'd0;
      alu_out_i = 32'd0;
      alu_ovf_i = 1'b0;
      case (alu_ctl_o)
         4'b0010: begin
            sum = {1'b0, alu_a_o} + {1'b0, alu_b_o};
            alu_out_i = sum[31:0];
            alu_ovf_i = sum[32];
         end
         4'b0110, 4'b0111: begin
            sum = {1'b0, alu_a_o} + {1'b0, ~alu_b_o} + 33'd1;
            alu_ovf_i = sum[32];
            alu_out_i = (alu_ctl_o == 4'b0111)
                        ? {31'd0, ($signed(alu_a_o) < $signed(alu_b_o))} : sum[31:0];
         end
         4'b0000: alu_out_i = alu_a_o & alu_b_o;
         4'b0001: alu_out_i = alu_a_o | alu_b_o;
         4'b1100: alu_out_i = ~(alu_a_o | alu_b_o);
         default: alu_out_i = 32'd0;
      endcase
      alu_zero_i = (alu_out_i == 32'd0);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, output int k);
      k = 0;
      while (rsp_valid_o !== 1'b1 && k < 20) begin
         chk({tag, "_busy_ready"}, 32'(req_ready_o), 32'd0);
         tick();
         k++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] e_ctl, input logic [31:0] e_a,
                         input logic [31:0] e_res, input logic e_z, input logic e_ovf,
                         input logic e_ill, input int e_lat);
      int k;
      req_aluop_i = op;
      req_funct_i = fn;
      req_a_i     = a;
      req_b_i     = b;
      req_valid_i = 1'b1;
      chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
      tick();
      req_valid_i = 1'b0;
      chk({tag, "_ctl"}, 32'(alu_ctl_o), 32'(e_ctl));
      chk({tag, "_alu_a"}, alu_a_o, e_a);
      wait_valid(tag, k);
      chk({tag, "_latency"}, 32'(k), 32'(e_lat));
      chk({tag, "_result"}, rsp_result_o, e_res);
      chk({tag, "_zero"}, 32'(rsp_zero_o), 32'(e_z));
      chk({tag, "_ovf"}, 32'(rsp_ovf_o), 32'(e_ovf));
      chk({tag, "_illegal"}, 32'(rsp_illegal_o), 32'(e_ill));
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      chk({tag, "_valid_clr"}, 32'(rsp_valid_o), 32'd0);
      chk({tag, "_ready_back"}, 32'(req_ready_o), 32'd1);
   endtask

   initial begin
      int k;
      reset_i     = 1'b1;
      req_valid_i = 1'b0;
      req_aluop_i = 2'b00;
      req_funct_i = 6'd0;
      req_a_i     = 32'd0;
      req_b_i     = 32'd0;
      rsp_ready_i = 1'b0;
      #1;
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      chk("rst_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_ctl", 32'(alu_ctl_o), 32'd0);
      chk("rst_alu_a", alu_a_o, 32'd0);
      chk("rst_result", rsp_result_o, 32'd0);
      chk("rst_illegal", 32'(rsp_illegal_o), 32'd0);
      tick();
      reset_i = 1'b0;
      tick();

      //     tag        op     funct      A             B             ctl      alu_a         result        z     ovf          ill   lat
      run_op("add",    2'b10, 6'b100000, 32'd5,        32'd7,        4'b0010, 32'd5,        32'd12,       1'b0, 1'b0,        1'b0, SETTLE);
      run_op("sub_eq", 2'b01, 6'b000000, 32'h1234,     32'h1234,     4'b0110, 32'h1234,     32'd0,        1'b1, !TRAP,       1'b0, SETTLE);
      run_op("slt",    2'b10, 6'b101010, 32'd3,        32'd9,        4'b0111, 32'd3,        32'd1,        1'b0, 1'b0,        1'b0, SETTLE);
      run_op("nor",    2'b10, 6'b100111, 32'd0,        32'd0,        4'b1100, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0,        1'b0, SETTLE);
      run_op("ill_fn", 2'b10, 6'b000001, 32'hDEAD,     32'hBEEF,     4'b1100, 32'd0,        32'd0,        1'b0, 1'b0,        1'b1, 0);
      run_op("and",    2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 4'b0000, 32'h0000F0F0, 32'h0000F000, 1'b0, 1'b0,        1'b0, SETTLE);
      run_op("or",     2'b10, 6'b100101, 32'h000000F0, 32'h0000000F, 4'b0001, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0,        1'b0, SETTLE);
      run_op("ill_op", 2'b11, 6'b100000, 32'h5555,     32'h1111,     4'b0001, 32'h000000F0, 32'd0,        1'b0, 1'b0,        1'b1, 0);
      run_op("sub_fn", 2'b10, 6'b100010, 32'd10,       32'd3,        4'b0110, 32'd10,       32'd7,        1'b0, !TRAP,       1'b0, SETTLE);
      run_op("add_co", 2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1,        4'b0010, 32'hFFFFFFFF, 32'd0,        1'b1, !TRAP,       1'b0, SETTLE);

      // Backpressure: response held, pending request not accepted until after the handshake.
      req_aluop_i = 2'b00;
      req_a_i     = 32'd1;
      req_b_i     = 32'd2;
      req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      wait_valid("hold", k);
      chk("hold_latency", 32'(k), 32'(SETTLE));
      req_a_i     = 32'd100;
      req_b_i     = 32'd1;
      req_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_valid", 32'(rsp_valid_o), 32'd1);
         chk("hold_result", rsp_result_o, 32'd3);
         chk("hold_ready", 32'(req_ready_o), 32'd0);
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      chk("hs_valid_clr", 32'(rsp_valid_o), 32'd0);
      chk("hs_no_accept", alu_a_o, 32'd1);
      chk("hs_ready", 32'(req_ready_o), 32'd1);
      tick();
      req_valid_i = 1'b0;
      chk("second_accept_ready", 32'(req_ready_o), 32'd0);
      chk("second_accept_alu_a", alu_a_o, 32'd100);

      // Reset in EXEC aborts the op.
      reset_i = 1'b1;
      #1;
      chk("abort_valid", 32'(rsp_valid_o), 32'd0);
      chk("abort_ready", 32'(req_ready_o), 32'd1);
      tick();
      reset_i = 1'b0;
      for (int i = 0; i < SETTLE + 2; i++) begin
         tick();
         chk("abort_no_rsp", 32'(rsp_valid_o), 32'd0);
      end

      run_op("add_ovf", 2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1, 4'b0010, 32'h7FFFFFFF,
             TRAP ? 32'd0 : 32'h80000000, 1'b0, TRAP, 1'b0, SETTLE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
